// File: rtl/echo_mix_pkg.sv
// echo_mix_pkg: shared constants and sample-format helpers for the echo mixer.
// Build option: MIX_ROUND_EN selects round-half-up wet scaling.
package echo_mix_pkg;

    localparam int D_WIDTH_DEF = 8;
    localparam int MIDSCALE    = 1 << (D_WIDTH_DEF - 1);
    localparam int SMAX        = MIDSCALE - 1;
    localparam int SMIN        = -MIDSCALE;

    typedef struct packed {
        logic signed [31:0] val;
        logic               sat;
    } sat_t;

    // offset-binary of width w to signed
    function automatic logic signed [31:0] ob_to_s(
        input logic [31:0] x,
        input int          w
    );
        return signed'(x) - (32'sd1 <<< (w - 1));
    endfunction

    // signed to offset-binary of width w (caller keeps the low w bits)
    function automatic logic [31:0] s_to_ob(
        input logic signed [31:0] s,
        input int                 w
    );
        return unsigned'(s + (32'sd1 <<< (w - 1)));
    endfunction

    // clamp to the signed range of width w and flag the clamp
    function automatic sat_t sat_d(
        input logic signed [31:0] s,
        input int                 w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sat_t               r;
        hi    = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo    = -(32'sd1 <<< (w - 1));
        r.val = s;
        r.sat = 1'b0;
        if (s > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (s < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/echo_mix_sat.sv
// echo_mix_sat: combinational wet scaling, dry+wet add and saturation.
// Build option: MIX_ROUND_EN rounds half-up instead of flooring the scaled wet.
module echo_mix_sat
    import echo_mix_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int G_WIDTH = 4
) (
    input  logic signed [D_WIDTH-1:0]         ds,
    input  logic signed [D_WIDTH+G_WIDTH:0]   prod,
    input  logic                              bypass,
    output logic        [D_WIDTH-1:0]         mix,
    output logic                              sat
);

    logic signed [31:0] prod_ext;
    logic signed [31:0] wet;
    logic signed [31:0] sum;
    sat_t               res;

    // scale the wet product, add to dry, clamp and return to offset-binary
    always_comb begin
        prod_ext = 32'(prod);
`ifdef MIX_ROUND_EN
        wet = (prod_ext + (32'sd1 <<< (G_WIDTH - 1))) >>> G_WIDTH;
`else
        wet = prod_ext >>> G_WIDTH;
`endif
        if (bypass) begin
            wet = '0;
        end
        sum = 32'(ds) + wet;
        res = sat_d(sum, D_WIDTH);
        mix = D_WIDTH'(s_to_ob(res.val, D_WIDTH));
        sat = res.sat;
    end

endmodule

// File: rtl/echo_mixer.sv
// echo_mixer: three-stage dry/wet echo mixer with saturation and clip counter.
// Build option: MIX_ROUND_EN (handled in echo_mix_sat) selects wet rounding.
module echo_mixer
    import echo_mix_pkg::*;
#(
    parameter int D_WIDTH        = D_WIDTH_DEF,
    parameter int G_WIDTH        = 4,
    parameter int CLIP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [D_WIDTH-1:0]        dry_sample,
    input  logic [D_WIDTH-1:0]        wet_sample,
    input  logic [G_WIDTH-1:0]        gain,
    input  logic                      bypass,
    output logic [D_WIDTH-1:0]        mix_out,
    output logic                      mix_valid,
    output logic                      clip,
    output logic [CLIP_CNT_WIDTH-1:0] clip_count
);

    localparam int P_W = D_WIDTH + G_WIDTH + 1;
    localparam logic [D_WIDTH-1:0] MID = {1'b1, {(D_WIDTH-1){1'b0}}};

    logic [D_WIDTH-1:0]        d1;
    logic                      v1;
    logic signed [D_WIDTH-1:0] ds2;
    logic signed [P_W-1:0]     p2;
    logic                      b2;
    logic                      v2;
    logic signed [D_WIDTH-1:0] ws;
    logic signed [P_W-1:0]     prod;
    logic [D_WIDTH-1:0]        mix3;
    logic                      sat3;

    assign ws   = D_WIDTH'(ob_to_s(32'(wet_sample), D_WIDTH));
    assign prod = P_W'(ws) * P_W'(signed'({1'b0, gain}));

    // stage 1: capture the dry sample while the RAM read is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= en;
            if (en) begin
                d1 <= dry_sample;
            end
        end
    end

    // stage 2: align dry with the RAM output, convert and multiply by gain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ds2 <= '0;
            p2  <= '0;
            b2  <= 1'b0;
            v2  <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                ds2 <= D_WIDTH'(ob_to_s(32'(d1), D_WIDTH));
                p2  <= prod;
                b2  <= bypass;
            end
        end
    end

    echo_mix_sat #(
        .D_WIDTH (D_WIDTH),
        .G_WIDTH (G_WIDTH)
    ) u_sat (
        .ds     (ds2),
        .prod   (p2),
        .bypass (b2),
        .mix    (mix3),
        .sat    (sat3)
    );

    // stage 3: register the mixed sample, strobes and the sticky clip count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mix_out    <= MID;
            mix_valid  <= 1'b0;
            clip       <= 1'b0;
            clip_count <= '0;
        end else begin
            mix_valid <= v2;
            clip      <= v2 & sat3;
            if (v2) begin
                mix_out <= mix3;
            end
            if (v2 && sat3 && clip_count != '1) begin
                clip_count <= clip_count + CLIP_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_echo_mixer.sv
// tb_echo_mixer: randomized and directed checks of echo_mixer against a
// sample-level reference model; a second instance has a 2-bit clip counter.
module tb_echo_mixer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       bypass = 1'b0;
    logic [7:0] dry = '0;
    logic [7:0] wet = '0;
    logic [3:0] gain = '0;

    logic [7:0]  mix_out;
    logic        mix_valid;
    logic        clip;
    logic [15:0] clip_count;
    logic [7:0]  mix_out_s;
    logic        mix_valid_s;
    logic        clip_s;
    logic [1:0]  clip_count_s;

    echo_mixer #(.D_WIDTH(8), .G_WIDTH(4), .CLIP_CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .dry_sample(dry), .wet_sample(wet),
        .gain(gain), .bypass(bypass), .mix_out(mix_out),
        .mix_valid(mix_valid), .clip(clip), .clip_count(clip_count)
    );

    echo_mixer #(.D_WIDTH(8), .G_WIDTH(4), .CLIP_CNT_WIDTH(2)) u_small (
        .clk(clk), .rst(rst), .en(en), .dry_sample(dry), .wet_sample(wet),
        .gain(gain), .bypass(bypass), .mix_out(mix_out_s),
        .mix_valid(mix_valid_s), .clip(clip_s), .clip_count(clip_count_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] out;
        bit         clp;
        int         cnt;
        int         cnts;
    } exp_t;

    exp_t       exp_q[int];
    int         n_checks = 0;
    int         n_fail = 0;
    int         m_cnt = 0;
    int         m_cnts = 0;
    logic [7:0] last_out = 8'h80;
    bit         pend_v = 0;
    logic [7:0] pend_d = '0;
    int         pend_c = 0;
    int         vcount = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    // sample-level reference: value arithmetic straight from the mixing rules
    task automatic model(input logic [7:0] d, input logic [7:0] w,
                         input logic [3:0] g, input bit b,
                         output logic [7:0] o, output bit c);
        int ds;
        int ws;
        int wv;
        int s;
        ds = int'(d) - 128;
        ws = int'(w) - 128;
        if (b) wv = 0;
`ifdef MIX_ROUND_EN
        else wv = $rtoi($floor(real'(ws * int'(g) + 8) / 16.0));
`else
        else wv = $rtoi($floor(real'(ws * int'(g)) / 16.0));
`endif
        s = ds + wv;
        c = 0;
        if (s > 127) begin s = 127; c = 1; end
        if (s < -128) begin s = -128; c = 1; end
        o = 8'(s + 128);
    endtask

    task automatic push(input logic [7:0] d, input logic [7:0] w,
                        input logic [3:0] g, input bit b, input int c);
        logic [7:0] o;
        bit         cl;
        model(d, w, g, b, o, cl);
        if (cl && m_cnt < 65535) m_cnt++;
        if (cl && m_cnts < 3) m_cnts++;
        exp_q[c + 3] = '{o, cl, m_cnt, m_cnts};
    endtask

    task automatic step(input bit e, input logic [7:0] d, input logic [7:0] w,
                        input logic [3:0] g, input bit b);
        @(negedge clk);
        en = e; dry = d; wet = w; gain = g; bypass = b;
        if (pend_v) push(pend_d, w, g, b, pend_c);
        pend_v = e;
        pend_d = d;
        pend_c = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 8'($urandom), 8'($urandom), 4'($urandom),
                        1'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        exp_q.delete();
        pend_v = 0;
        m_cnt = 0;
        m_cnts = 0;
        last_out = 8'h80;
        #1;
        chk("rst_now_out", mix_out, 8'h80);
        chk("rst_now_valid", mix_valid, 0);
        chk("rst_now_cnt", clip_count, 0);
        chk("rst_now_cnt_small", clip_count_s, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // one isolated sample; returns the outputs seen three cycles after en
    task automatic shot(input logic [7:0] d, input logic [7:0] w,
                        input logic [3:0] g, input bit b,
                        output logic [7:0] o, output bit c,
                        output int cnt, output int cnts);
        step(1, d, 8'($urandom), 4'($urandom), 1'($urandom));
        step(0, 8'($urandom), w, g, b);
        step(0, 8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom));
        @(posedge clk);
        #2;
        o = mix_out;
        c = clip;
        cnt = int'(clip_count);
        cnts = int'(clip_count_s);
    endtask

    // every cycle: outputs must match the model's schedule of results
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("reset_out", mix_out, 8'h80);
                chk("reset_valid", mix_valid, 0);
                chk("reset_clip", clip, 0);
                chk("reset_cnt", clip_count, 0);
                chk("reset_cnt_small", clip_count_s, 0);
            end else if (exp_q.exists(cyc)) begin
                e = exp_q[cyc];
                chk("valid", mix_valid, 1);
                chk("mix_out", mix_out, e.out);
                chk("clip", clip, 32'(e.clp));
                chk("clip_count", clip_count, e.cnt);
                chk("valid_small", mix_valid_s, 1);
                chk("mix_out_small", mix_out_s, e.out);
                chk("clip_small", clip_s, 32'(e.clp));
                chk("clip_count_small", clip_count_s, e.cnts);
                last_out = e.out;
                exp_q.delete(cyc);
            end else begin
                chk("idle_valid", mix_valid, 0);
                chk("idle_clip", clip, 0);
                chk("hold_out", mix_out, last_out);
                chk("idle_valid_small", mix_valid_s, 0);
            end
            if (!rst && mix_valid) vcount++;
        end
    end

    initial begin
        logic [7:0] o;
        bit         c;
        int         cnt;
        int         cnts;
        logic [7:0] sw[64];
        logic [3:0] sg[64];
        bit         sb[64];
        int         sat_exp[5];

        sat_exp = '{1, 2, 3, 3, 3};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(3);

        shot(8'h80, 8'hFF, 4'd8, 0, o, c, cnt, cnts);
`ifdef MIX_ROUND_EN
        chk("nominal_out", o, 8'hC0);
`else
        chk("nominal_out", o, 8'hBF);
`endif
        chk("nominal_clip", c, 0);

        shot(8'hF0, 8'hFF, 4'd15, 0, o, c, cnt, cnts);
        chk("pos_clip_out", o, 8'hFF);
        chk("pos_clip_flag", c, 1);
        chk("pos_clip_cnt", cnt, 1);

        shot(8'h00, 8'h01, 4'd15, 0, o, c, cnt, cnts);
        chk("neg_clip_out", o, 8'h00);
        chk("neg_clip_flag", c, 1);
        chk("neg_clip_cnt", cnt, 2);

        shot(8'h80, 8'h81, 4'd8, 0, o, c, cnt, cnts);
`ifdef MIX_ROUND_EN
        chk("round_out", o, 8'h81);
`else
        chk("round_out", o, 8'h80);
`endif

        shot(8'h37, 8'hFF, 4'd0, 0, o, c, cnt, cnts);
        chk("gain0_out", o, 8'h37);

        shot(8'h12, 8'hFF, 4'd15, 1, o, c, cnt, cnts);
        chk("bypass_out", o, 8'h12);
        chk("bypass_clip", c, 0);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            shot(8'hF0, 8'hFF, 4'd15, 0, o, c, cnt, cnts);
            chk("small_cnt_sat", cnts, sat_exp[i]);
        end

        for (int i = 0; i < 64; i++) begin
            sw[i] = 8'(i);
            sg[i] = (i % 2 == 1) ? 4'd15 : 4'd0;
            sb[i] = (i >= 10 && i <= 12);
        end
        idle(2);
        vcount = 0;
        step(1, 8'h00, 8'h00, 4'd0, 0);
        for (int i = 1; i < 64; i++)
            step(1, 8'(i), sw[i-1], sg[i-1], sb[i-1]);
        step(0, 8'h00, sw[63], sg[63], sb[63]);
        idle(4);
        chk("stream_valid_run", vcount, 64);

        repeat (400) begin
            if ($urandom_range(3) != 0)
                step(1, 8'($urandom), 8'($urandom), 4'($urandom),
                     ($urandom_range(7) == 0));
            else
                step(0, 8'($urandom), 8'($urandom), 4'($urandom),
                     ($urandom_range(7) == 0));
        end

        repeat (30) step(1, 8'($urandom), 8'($urandom), 4'($urandom), 0);
        do_reset();
        idle(6);

        repeat (300) begin
            step(($urandom_range(3) != 0), 8'($urandom), 8'($urandom),
                 4'($urandom), ($urandom_range(7) == 0));
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_mixer.md
Name: echo_mixer

Overview:
- Downstream stage of the signal-delay block; combines the live microphone sample ("dry") with the RAM-delayed sample ("wet") into a single echo output.
- Applies a programmable fractional gain to the wet path, then adds it to the dry path with saturation.
- Three-stage pipeline with a valid strobe; also keeps a running clip counter.
- Absorbs the one-cycle synchronous-RAM read latency internally, so it takes the same sample strobe that drives the delay line.

Parameters:
- D_WIDTH, 8, sample width; samples are offset-binary (midscale 2^(D_WIDTH-1) = silence).
- G_WIDTH, 4, gain width; wet factor = gain / 2^G_WIDTH.
- CLIP_CNT_WIDTH, 16, width of the clip event counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  sample strobe, same strobe as the delay-line write/read enable.
- dry_sample  input  D_WIDTH  live mic sample; valid in the en cycle.
- wet_sample  input  D_WIDTH  delayed sample from RAM; valid in the cycle after en.
- gain  input  G_WIDTH  wet gain numerator; sampled together with wet_sample.
- bypass  input  1  1 = output dry only; sampled together with wet_sample.
- mix_out  output  D_WIDTH  mixed sample, offset-binary.
- mix_valid  output  1  one-cycle pulse per accepted en.
- clip  output  1  pulses with mix_valid when the sum saturated.
- clip_count  output  CLIP_CNT_WIDTH  number of saturated samples; sticks at all-ones.

Behaviour:
- Reset (asynchronous, any time):
  - mix_out = 2^(D_WIDTH-1); mix_valid = 0; clip = 0; clip_count = 0.
  - All pipeline valid bits cleared; in-flight samples are discarded and never emitted.
- Stage 1, clock edge ending cycle n with en=1: register dry_sample; set v1.
- Stage 2, edge ending cycle n+1 when v1=1:
  - Convert to signed: ds = dry - 2^(D-1), ws = wet - 2^(D-1).
  - Register ds, the product p = ws * gain (signed, D+G+1 bits), bypass, and set v2.
- Stage 3, edge ending cycle n+2 when v2=1:
  - Scaled wet: w = p >>> G_WIDTH (arithmetic shift, floor).
  - Sum: s = ds + w, (D+1)-bit signed.
  - Saturate s to [-2^(D-1), 2^(D-1)-1]; sat = 1 if the value was clamped.
  - mix_out = saturated s + 2^(D-1); mix_valid = 1; clip = sat.
- Latency: en in cycle n gives mix_valid=1 and a valid mix_out in cycle n+3.
- Throughput: en may be high every cycle; one output per en, with no bubbles and no reordering.
- When the stage-3 valid bit is 0: mix_valid = 0, clip = 0, mix_out holds its last value.
- bypass=1: mix_out = dry_sample, same latency, clip = 0. The wet path is ignored.
- gain=0: mix_out = dry_sample. Maximum gain (all-ones) gives a factor of (2^G-1)/2^G, never unity.
- clip_count increments on each clip pulse and saturates at 2^CLIP_CNT_WIDTH-1 (no wrap).
- gain and bypass changes take effect per sample; no glitch on a sample already in stage 3.

Optional Feature:
- Macro: MIX_ROUND_EN.
- Defined: round-half-up, w = (p + 2^(G_WIDTH-1)) >>> G_WIDTH.
- Undefined: truncation toward -infinity, w = p >>> G_WIDTH.
- Latency and interface are identical in both builds.

Decomposition:
- Package echo_mix_pkg:
  - Constants: MIDSCALE, SMAX, SMIN, all derived from D_WIDTH.
  - Functions: ob_to_s (offset-binary to signed), s_to_ob (signed to offset-binary), sat_d (saturate, returning the clamped value and the sat flag).
- Sub-module echo_mix_sat: stage-3 scale, add and saturate datapath (combinational); the top owns all registers and the counter.

Test Plan (D=8, G=4 unless stated):
- Reset: assert rst mid-stream with en pulses in flight -> immediately mix_out=0x80, mix_valid=0, clip_count=0; after release, no mix_valid without a new en.
- Nominal mix: dry=0x80, wet=0xFF, gain=8 -> cycle n+3: mix_out=0xBF (127*8>>4=63), clip=0.
- Positive clip: dry=0xF0, wet=0xFF, gain=15 -> 112+119=231, so mix_out=0xFF, clip=1, clip_count=1. Negative: dry=0x00, wet=0x01, gain=15 -> mix_out=0x00, clip=1, clip_count=2.
- Rounding: dry=0x80, wet=0x81, gain=8 -> mix_out=0x80 without MIX_ROUND_EN, 0x81 with it.
- Streaming alignment: en every cycle for 64 cycles; dry ramp 0x00..0x3F; wet = dry of the previous cycle; gain toggling 0/15; bypass set on samples 10-12 -> every output matches the reference model, mix_valid continuously high for 64 cycles, and the bypass samples equal dry.
- Counter saturation: CLIP_CNT_WIDTH=2, drive 5 clipping samples -> clip_count reads 1, 2, 3, 3, 3.
